// File: rtl/ps2_led_sync_if.sv
// ps2_led_sync_if
// Byte-level link between the LED synchroniser and the shared PS/2 host
// transmitter / received-code stream.
//   tx_start          one-cycle request to send tx_data
//   tx_data           byte to send
//   tx_busy           transmitter busy (high the cycle after tx_start until sent)
//   code_new_updated  one-cycle strobe marking a new received byte
//   check_code        received byte, valid with code_new_updated
// Modports: master = the synchroniser, slave = transmitter/receiver side.
interface ps2_led_sync_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       code_new_updated;
    logic [7:0] check_code;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  code_new_updated,
        input  check_code
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output code_new_updated,
        output check_code
    );
endinterface

// File: rtl/ps2_led_sync.sv
// ps2_led_sync
// Sends the requested keyboard LED state with the PS/2 Set-LEDs sequence
// (0xED, ACK, mask byte, ACK) through the shared host transmitter and watches
// the received-code stream for ACK (0xFA) / Resend (0xFE).
// Optional feature macro: PS2_LED_SYNC_RETRY_EN
//   defined   : Resend or timeout re-sends the current byte up to MAX_RETRY times
//   undefined : Resend or timeout abandons the transfer immediately
// Ports:
//   clk_2        system clock
//   rst          synchronous active-high reset
//   clk_300k     count enable for the response timeout
//   led_req      requested LED mask {caps, num, scroll}
//   led_applied  last mask acknowledged by the keyboard
//   busy         transfer in progress
//   error        last transfer abandoned; cleared by the next success
//   link         transmitter / received-code link (master side)
module ps2_led_sync #(
    parameter int TIMEOUT   = 3000,
    parameter int MAX_RETRY = 3
) (
    input  logic                  clk_2,
    input  logic                  rst,
    input  logic                  clk_300k,
    input  logic [2:0]            led_req,
    output logic [2:0]            led_applied,
    output logic                  busy,
    output logic                  error,
    ps2_led_sync_if.master        link
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_ACK,
        DONE,
        FAIL
    } state_t;

    localparam logic [11:0] TMO_LIMIT = 12'(TIMEOUT);

    // The retry counter is two bits wide; larger values cannot be honoured.
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_max_retry
        $error("MAX_RETRY must be in 0..3");
    end
    if (TIMEOUT < 0 || TIMEOUT > 4095) begin : g_bad_timeout
        $error("TIMEOUT must fit in 12 bits");
    end

    state_t      state;
    logic [2:0]  last_req;
    logic [2:0]  mask;
    logic [11:0] tmo;
    logic        byte_sel;
    logic        tx_first;
`ifdef PS2_LED_SYNC_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    logic [1:0]  retry;
`endif

    logic is_ack;
    logic is_resend;
    logic tmo_hit;

    assign is_ack    = link.code_new_updated && (link.check_code == 8'hFA);
    assign is_resend = link.code_new_updated && (link.check_code == 8'hFE);
    assign tmo_hit   = (tmo >= TMO_LIMIT);

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state         <= IDLE;
            link.tx_start <= 1'b0;
            link.tx_data  <= 8'h00;
            led_applied   <= 3'b000;
            busy          <= 1'b0;
            error         <= 1'b0;
            last_req      <= 3'b000;
            mask          <= 3'b000;
            tmo           <= 12'd0;
            byte_sel      <= 1'b0;
            tx_first      <= 1'b0;
`ifdef PS2_LED_SYNC_RETRY_EN
            retry         <= 2'd0;
`endif
        end else begin
            link.tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is released here rather than on leaving DONE/FAIL so
                    // it stays high through the cycle where the result appears.
                    busy <= (led_req != last_req);
                    if (led_req != last_req) begin
                        mask     <= led_req;
                        last_req <= led_req;
                        byte_sel <= 1'b0;
`ifdef PS2_LED_SYNC_RETRY_EN
                        retry    <= 2'd0;
`endif
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (!link.tx_busy) begin
                        link.tx_data  <= byte_sel ? {5'b00000, mask} : 8'hED;
                        link.tx_start <= 1'b1;
                        tx_first      <= 1'b1;
                        state         <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    // tx_busy only rises the cycle after tx_start, so the first
                    // sample here would see a stale idle transmitter.
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (!link.tx_busy) begin
                        tmo   <= 12'd0;
                        state <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    // A strobe's code takes priority over a simultaneous timeout;
                    // unrelated scan codes fall through and are ignored.
                    if (is_ack) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
`ifdef PS2_LED_SYNC_RETRY_EN
                            retry    <= 2'd0;
`endif
                            state    <= SEND;
                        end else begin
                            state <= DONE;
                        end
                    end else if (is_resend || tmo_hit) begin
`ifdef PS2_LED_SYNC_RETRY_EN
                        if (retry < RETRY_LIMIT) begin
                            retry <= retry + 2'd1;
                            state <= SEND;
                        end else begin
                            state <= FAIL;
                        end
`else
                        state <= FAIL;
`endif
                    end else if (clk_300k && !tmo_hit) begin
                        tmo <= tmo + 12'd1;
                    end
                end

                DONE: begin
                    led_applied <= mask;
                    error       <= 1'b0;
                    state       <= IDLE;
                end

                FAIL: begin
                    error <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_led_sync.sv
// tb_ps2_led_sync
// Scoreboard bench for ps2_led_sync: expected transmitted bytes are queued when
// a request is driven and compared when the DUT pulses tx_start. A transmitter
// model raises tx_busy for a few cycles and a keyboard model returns queued
// responses (optionally preceded by unrelated scan codes).
module tb_ps2_led_sync;
    localparam int TMO   = 20;
    localparam int TXLEN = 5;
    localparam int RDLY  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_300k;
    logic [2:0] led_req;
    logic [2:0] led_applied;
    logic       busy;
    logic       error;

    ps2_led_sync_if bus();

    ps2_led_sync #(.TIMEOUT(TMO), .MAX_RETRY(3)) dut (
        .clk_2      (clk),
        .rst        (rst),
        .clk_300k   (clk_300k),
        .led_req    (led_req),
        .led_applied(led_applied),
        .busy       (busy),
        .error      (error),
        .link       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] strobe_q[$];
    bit         noise_en    = 1'b0;
    bit         start_prev  = 1'b0;
    int         tx_cnt      = 0;
    int         gap         = 0;
    int         last_fa_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter + keyboard model and tx_start scoreboard, sampled 1 ns after the edge.
    initial begin
        logic [8:0] e;
        bus.tx_busy          = 1'b0;
        bus.code_new_updated = 1'b0;
        bus.check_code       = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                check_eq("tx_byte", 32'(bus.tx_data), 32'(e));
                check_eq("tx_start_while_busy", 32'(bus.tx_busy), 32'd0);
                check_eq("tx_start_width", 32'(start_prev), 32'd0);
            end
            if (start_prev) begin
                bus.tx_busy = 1'b1;
                tx_cnt      = TXLEN;
            end else if (bus.tx_busy) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    if (noise_en) begin
                        strobe_q.push_back(8'h1C);
                        strobe_q.push_back(8'hF0);
                        strobe_q.push_back(8'h1C);
                    end
                    if (resp_q.size() > 0) strobe_q.push_back(resp_q.pop_front());
                    gap = RDLY;
                end
            end
            start_prev = bus.tx_start;
            if (bus.code_new_updated) begin
                bus.code_new_updated = 1'b0;
            end else if (gap > 0) begin
                gap--;
            end else if (strobe_q.size() > 0) begin
                bus.check_code       = strobe_q.pop_front();
                bus.code_new_updated = 1'b1;
                if (bus.check_code == 8'hFA) last_fa_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_led(input logic [2:0] v, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            tick();
            n++;
            if (led_applied == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx_fall(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!bus.tx_busy && n < budget) begin
            tick();
            n++;
        end
        while (bus.tx_busy && n < budget) begin
            tick();
            n++;
        end
        ok = (n < budget);
    endtask

    initial begin
        bit         ok;
        logic [2:0] exp_led;

        rst      = 1'b1;
        clk_300k = 1'b1;
        led_req  = 3'b000;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_led_applied", 32'(led_applied), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'h00);
        rst = 1'b0;
        tick();

        // Basic transfer: ED, 05 with ACK after each
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h005);
        resp_q.push_back(8'hFA); resp_q.push_back(8'hFA);
        led_req = 3'b101;
        tick();
        check_eq("basic_busy_rise", 32'(busy), 32'd1);
        tick();
        check_eq("basic_tx_start", 32'(bus.tx_start), 32'd1);
        wait_led(3'b101, 300, ok);
        check_eq("basic_led_seen", 32'(ok), 32'd1);
        check_eq("basic_ack_to_led", 32'(cyc - last_fa_cyc), 32'd2);
        check_eq("basic_busy_hold", 32'(busy), 32'd1);
        tick();
        check_eq("basic_busy_drop", 32'(busy), 32'd0);
        check_eq("basic_error", 32'(error), 32'd0);
        check_eq("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Resend on the mask byte
        led_req = 3'b000;
        do_reset();
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h005);
        resp_q.push_back(8'hFA); resp_q.push_back(8'hFE);
`ifdef PS2_LED_SYNC_RETRY_EN
        exp_q.push_back(9'h005);
        resp_q.push_back(8'hFA);
        exp_led = 3'b101;
`else
        exp_led = 3'b000;
`endif
        led_req = 3'b101;
        tick();
        wait_idle("resend_idle", 400);
        check_eq("resend_led", 32'(led_applied), 32'(exp_led));
`ifdef PS2_LED_SYNC_RETRY_EN
        check_eq("resend_error", 32'(error), 32'd0);
`else
        check_eq("resend_error", 32'(error), 32'd1);
`endif
        check_eq("resend_q_empty", 32'(exp_q.size()), 32'd0);

        // No response: timeout path, led_applied must keep its value
        exp_q.push_back(9'h0ED);
`ifdef PS2_LED_SYNC_RETRY_EN
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h0ED); exp_q.push_back(9'h0ED);
`endif
        led_req = 3'b111;
        tick();
        wait_idle("tmo_idle", 800);
        check_eq("tmo_error", 32'(error), 32'd1);
        check_eq("tmo_led_kept", 32'(led_applied), 32'(exp_led));
        check_eq("tmo_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (10) tick();
        check_eq("tmo_no_reattempt", 32'(busy), 32'd0);

        // Unrelated scan codes before each ACK
        noise_en = 1'b1;
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h002);
        resp_q.push_back(8'hFA); resp_q.push_back(8'hFA);
        led_req = 3'b010;
        wait_led(3'b010, 400, ok);
        check_eq("noise_led_seen", 32'(ok), 32'd1);
        wait_idle("noise_idle", 50);
        check_eq("noise_error_cleared", 32'(error), 32'd0);
        check_eq("noise_q_empty", 32'(exp_q.size()), 32'd0);
        noise_en = 1'b0;

        // Request change during the first ACK wait
        led_req = 3'b000;
        do_reset();
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h001);
        exp_q.push_back(9'h0ED); exp_q.push_back(9'h003);
        repeat (4) resp_q.push_back(8'hFA);
        led_req = 3'b001;
        wait_tx_fall(100, ok);
        check_eq("chg_first_tx", 32'(ok), 32'd1);
        led_req = 3'b011;
        wait_led(3'b001, 300, ok);
        check_eq("chg_led_first", 32'(ok), 32'd1);
        check_eq("chg_still_busy", 32'(busy), 32'd1);
        wait_led(3'b011, 400, ok);
        check_eq("chg_led_second", 32'(ok), 32'd1);
        wait_idle("chg_idle", 50);
        check_eq("chg_error", 32'(error), 32'd0);
        check_eq("chg_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset while waiting for the ACK; the late FA must be ignored
        exp_q.push_back(9'h0ED);
        resp_q.push_back(8'hFA);
        led_req = 3'b100;
        wait_tx_fall(100, ok);
        check_eq("rstmid_tx", 32'(ok), 32'd1);
        tick();
        rst     = 1'b1;
        led_req = 3'b000;
        tick();
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_led", 32'(led_applied), 32'd0);
        check_eq("rstmid_tx_start", 32'(bus.tx_start), 32'd0);
        rst = 1'b0;
        repeat (30) tick();
        check_eq("rstmid_fa_delivered", 32'(strobe_q.size()), 32'd0);
        check_eq("rstmid_busy_after", 32'(busy), 32'd0);
        check_eq("rstmid_led_after", 32'(led_applied), 32'd0);
        check_eq("rstmid_error_after", 32'(error), 32'd0);
        check_eq("rstmid_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
